// File: rtl/spi_slave_rx_tx.sv
// SPI mode-0 responder: oversamples sclk/cs/mosi in the clk domain, receives one
// MSB-first word per frame and returns the shadow word on miso LSB-first.
module spi_slave_rx_tx #(
   parameter int N    = 8,
   parameter int SYNC = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         sclk,
   input  logic         cs,
   input  logic         mosi,
   output logic         miso,
   output logic         miso_oe,
   input  logic [N-1:0] tx_data,
   input  logic         tx_load,
   output logic [N-1:0] rx_data,
   output logic         rx_valid,
   output logic         abort
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      HOLD
   } state_t;

   state_t          state;
   state_t          state_next;

   logic [1:0]      rst_pipe;
   logic            rst;

   logic [SYNC-1:0] sclk_sync;
   logic [SYNC-1:0] cs_sync;
   logic [SYNC-1:0] mosi_sync;
   logic            sclk_prev;
   logic            cs_prev;
   logic            sclk_s;
   logic            cs_s;
   logic            mosi_s;
   logic            sclk_rise;
   logic            sclk_fall;
   logic            cs_rise;
   logic            cs_fall;

   logic [N-1:0]    shadow;
   logic [N-1:0]    tx_shift;
   logic [N-1:0]    rx_shift;
   logic [N-1:0]    rx_next;
   logic [CW-1:0]   bit_cnt;

   logic            start_frame;
   logic            end_frame;
   logic            do_abort;
   logic            take_bit;
   logic            last_bit;
   logic            shift_out;

   // Reset asserts immediately but releases two clocks later, on a clk edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rst_pipe <= 2'b11;
      end else begin
         rst_pipe <= {rst_pipe[0], 1'b0};
      end
   end

   assign rst = reset | rst_pipe[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC-2:0], cs};
         mosi_sync <= {mosi_sync[SYNC-2:0], mosi};
         sclk_prev <= sclk_s;
         cs_prev   <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync[SYNC-1];
   assign cs_s      = cs_sync[SYNC-1];
   assign mosi_s    = mosi_sync[SYNC-1];
   assign sclk_rise = sclk_s & ~sclk_prev;
   assign sclk_fall = ~sclk_s & sclk_prev;
   assign cs_rise   = cs_s & ~cs_prev;
   assign cs_fall   = ~cs_s & cs_prev;
   assign rx_next   = {rx_shift[N-2:0], mosi_s};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // cs rising takes priority over any sclk edge seen on the same sample.
   always_comb begin
      state_next  = state;
      start_frame = 1'b0;
      end_frame   = 1'b0;
      do_abort    = 1'b0;
      take_bit    = 1'b0;
      last_bit    = 1'b0;
      shift_out   = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall) begin
               start_frame = 1'b1;
               state_next  = ACTIVE;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               end_frame  = 1'b1;
               do_abort   = 1'b1;
               state_next = IDLE;
            end else if (sclk_rise) begin
               take_bit = 1'b1;
               if (bit_cnt == CW'(N - 1)) begin
                  last_bit   = 1'b1;
                  state_next = HOLD;
               end
            end else if (sclk_fall) begin
               shift_out = 1'b1;
            end
         end
         HOLD: begin
            if (cs_rise) begin
               end_frame  = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow   <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         rx_data  <= '0;
         bit_cnt  <= '0;
         miso     <= 1'b0;
         miso_oe  <= 1'b0;
         rx_valid <= 1'b0;
         abort    <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         abort    <= 1'b0;
         if (tx_load) begin
            shadow <= tx_data;
         end
         if (start_frame) begin
            tx_shift <= shadow;
            miso     <= shadow[0];
            miso_oe  <= 1'b1;
            bit_cnt  <= '0;
            rx_shift <= '0;
         end else if (end_frame) begin
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            abort   <= do_abort;
         end else if (take_bit) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + CW'(1);
            if (last_bit) begin
               rx_data  <= rx_next;
               rx_valid <= 1'b1;
            end
         end else if (shift_out) begin
            tx_shift <= tx_shift >> 1;
            miso     <= tx_shift[1];
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Directed bench for spi_slave_rx_tx: a behavioural mode-0 master at clk/8 drives
// frames and each scenario task compares against hand-computed words.
module tb_spi_slave_rx_tx;

   logic       clk;
   logic       reset;
   logic       sclk;
   logic       cs;
   logic       mosi;
   logic       miso;
   logic       miso_oe;
   logic [7:0] tx_data;
   logic       tx_load;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       abort;

   int compared;
   int mismatched;
   int valid_total;
   int abort_total;
   int overlap_total;

   spi_slave_rx_tx #(.N(8), .SYNC(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .sclk    (sclk),
      .cs      (cs),
      .mosi    (mosi),
      .miso    (miso),
      .miso_oe (miso_oe),
      .tx_data (tx_data),
      .tx_load (tx_load),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .abort   (abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Running strobe tallies; scenarios compare before/after snapshots.
   always @(negedge clk) begin
      if (rx_valid) valid_total++;
      if (abort) abort_total++;
      if (rx_valid && abort) overlap_total++;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // One master frame: nbits sclk pulses, extra pulses afterwards, optional tx_load
   // after bit load_bit; miso is sampled just before each master rising edge.
   task automatic run_frame(input logic [7:0] word, input int nbits, input int extra,
                            input int load_bit, input logic [7:0] load_val,
                            output logic [7:0] miso_word, output logic oe_hold);
      miso_word = 8'h00;
      @(negedge clk);
      cs   = 1'b0;
      mosi = word[7];
      repeat (4) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         miso_word[i] = miso;
         sclk = 1'b1;
         repeat (4) @(negedge clk);
         sclk = 1'b0;
         if (i < 7) mosi = word[6-i];
         if (i == load_bit) begin
            tx_data = load_val;
            tx_load = 1'b1;
            @(negedge clk);
            tx_load = 1'b0;
            repeat (3) @(negedge clk);
         end else begin
            repeat (4) @(negedge clk);
         end
      end
      for (int e = 0; e < extra; e++) begin
         mosi = ~mosi;
         sclk = 1'b1;
         repeat (4) @(negedge clk);
         sclk = 1'b0;
         repeat (4) @(negedge clk);
      end
      oe_hold = miso_oe;
      cs      = 1'b1;
      mosi    = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      sclk    = 1'b0;
      cs      = 1'b1;
      mosi    = 1'b0;
      tx_data = 8'h00;
      tx_load = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_miso", 32'(miso), 32'h0);
      check("reset_miso_oe", 32'(miso_oe), 32'h0);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check("reset_rx_data", 32'(rx_data), 32'h00);
      check("reset_rx_valid", 32'(rx_valid), 32'h0);
      check("reset_abort", 32'(abort), 32'h0);
   endtask

   task automatic test_basic();
      logic [7:0] mw;
      logic       oe;
      int         v0;
      int         a0;
      tx_data = 8'hA5;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
      v0 = valid_total;
      a0 = abort_total;
      run_frame(8'h3C, 8, 0, -1, 8'h00, mw, oe);
      check("basic_rx_data", 32'(rx_data), 32'h3C);
      check("basic_miso_word", 32'(mw), 32'hA5);
      check("basic_valid_pulses", 32'(valid_total - v0), 32'd1);
      check("basic_no_abort", 32'(abort_total - a0), 32'd0);
      check("basic_oe_in_hold", 32'(oe), 32'h1);
      check("basic_oe_after_cs", 32'(miso_oe), 32'h0);
   endtask

   task automatic test_back_to_back();
      logic [7:0] mw;
      logic       oe;
      int         v0;
      v0 = valid_total;
      run_frame(8'h81, 8, 0, -1, 8'h00, mw, oe);
      check("b2b_rx_data_1", 32'(rx_data), 32'h81);
      check("b2b_miso_word_1", 32'(mw), 32'hA5);
      run_frame(8'h7E, 8, 0, -1, 8'h00, mw, oe);
      check("b2b_rx_data_2", 32'(rx_data), 32'h7E);
      check("b2b_miso_word_2", 32'(mw), 32'hA5);
      check("b2b_valid_pulses", 32'(valid_total - v0), 32'd2);
   endtask

   task automatic test_abort();
      logic [7:0] mw;
      logic       oe;
      int         v0;
      int         a0;
      v0 = valid_total;
      a0 = abort_total;
      run_frame(8'h12, 5, 0, -1, 8'h00, mw, oe);
      check("abort_pulses", 32'(abort_total - a0), 32'd1);
      check("abort_no_valid", 32'(valid_total - v0), 32'd0);
      check("abort_rx_kept", 32'(rx_data), 32'h7E);
      check("abort_oe_off", 32'(miso_oe), 32'h0);
      run_frame(8'hFF, 8, 0, -1, 8'h00, mw, oe);
      check("abort_next_rx", 32'(rx_data), 32'hFF);
   endtask

   task automatic test_midframe_load();
      logic [7:0] mw;
      logic       oe;
      run_frame(8'h11, 8, 0, 3, 8'h0F, mw, oe);
      check("midload_cur_miso", 32'(mw), 32'hA5);
      check("midload_cur_rx", 32'(rx_data), 32'h11);
      run_frame(8'h22, 8, 0, -1, 8'h00, mw, oe);
      check("midload_next_miso", 32'(mw), 32'h0F);
      check("midload_next_rx", 32'(rx_data), 32'h22);
   endtask

   task automatic test_extra_pulses();
      logic [7:0] mw;
      logic       oe;
      int         v0;
      int         a0;
      v0 = valid_total;
      a0 = abort_total;
      run_frame(8'h5A, 8, 3, -1, 8'h00, mw, oe);
      check("extra_rx_data", 32'(rx_data), 32'h5A);
      check("extra_valid_pulses", 32'(valid_total - v0), 32'd1);
      check("extra_no_abort", 32'(abort_total - a0), 32'd0);
      check("extra_oe_held", 32'(oe), 32'h1);
      check("extra_miso_word", 32'(mw), 32'h0F);
   endtask

   task automatic test_reset_midframe();
      logic [7:0] mw;
      logic       oe;
      int         v0;
      int         a0;
      v0 = valid_total;
      a0 = abort_total;
      @(negedge clk);
      cs   = 1'b0;
      mosi = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         sclk = 1'b1;
         repeat (4) @(negedge clk);
         sclk = 1'b0;
         repeat (4) @(negedge clk);
      end
      check("midrst_oe_before", 32'(miso_oe), 32'h1);
      reset = 1'b1;
      #1;
      check("midrst_miso_oe", 32'(miso_oe), 32'h0);
      check("midrst_miso", 32'(miso), 32'h0);
      check("midrst_rx_data", 32'(rx_data), 32'h00);
      @(negedge clk);
      cs   = 1'b1;
      mosi = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      check("midrst_no_valid", 32'(valid_total - v0), 32'd0);
      check("midrst_no_abort", 32'(abort_total - a0), 32'd0);
      run_frame(8'hC3, 8, 0, -1, 8'h00, mw, oe);
      check("midrst_next_rx", 32'(rx_data), 32'hC3);
      check("midrst_next_miso", 32'(mw), 32'h00);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_abort();
      test_midframe_load();
      test_extra_pulses();
      test_reset_midframe();
      check("valid_abort_overlap", 32'(overlap_total), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
